// File: rtl/n64_pkg.sv
// n64_pkg: shared constants and state encoding for the N64 controller responder.
//   CMD_*          command bytes the responder decodes
//   REPLY_LEN_*    reply lengths in bits
//   state_t        responder FSM states
package n64_pkg;

    localparam logic [7:0] CMD_INFO  = 8'h00;
    localparam logic [7:0] CMD_POLL  = 8'h01;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    localparam logic [5:0] REPLY_LEN_ID   = 6'd24;
    localparam logic [5:0] REPLY_LEN_POLL = 6'd32;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_BIT,
        ST_RX_WAIT,
        ST_TURNAROUND,
        ST_TX_BIT,
        ST_TX_STOP,
        ST_DISCARD
    } state_t;

endpackage

// File: rtl/n64_bit_tx.sv
// n64_bit_tx: drives one bus bit (or the reply stop bit) onto the open-drain line.
//   clk, reset   clock and synchronous active-high reset
//   start        begin a bit; bit_val and stop are captured on this cycle
//   bit_val      '1' = 1 us low + 3 us high, '0' = 3 us low + 1 us high
//   stop         stop bit: 2 us low, then release with no high phase
//   line_oe      1 = pull the bus low
//   done         high on the last cycle of the bit; a start on that cycle
//                chains the next bit with no gap
//
// phase   | meaning
// PH_IDLE | line released, waiting for start
// PH_LOW  | pulling the line low
// PH_HIGH | line released for the remainder of the bit
module n64_bit_tx #(
    parameter int CLK_PER_US = 33
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    input  logic stop,
    output logic line_oe,
    output logic done
);
    import n64_pkg::*;

    typedef enum logic [1:0] {PH_IDLE, PH_LOW, PH_HIGH} phase_t;

    localparam logic [CNT_W-1:0] T1 = CNT_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] T2 = CNT_W'(2 * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] T3 = CNT_W'(3 * CLK_PER_US - 1);

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             bit_q, bit_q_nxt;
    logic             stop_q, stop_q_nxt;
    logic             tc;

    assign tc      = (cnt == '0);
    assign line_oe = (phase == PH_LOW);
    assign done    = tc && ((phase == PH_HIGH) || (phase == PH_LOW && stop_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= PH_IDLE;
            cnt    <= '0;
            bit_q  <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            cnt    <= cnt_nxt;
            bit_q  <= bit_q_nxt;
            stop_q <= stop_q_nxt;
        end
    end

    always_comb begin
        phase_nxt  = phase;
        cnt_nxt    = tc ? cnt : cnt - 1'b1;
        bit_q_nxt  = bit_q;
        stop_q_nxt = stop_q;
        if (start) begin
            phase_nxt  = PH_LOW;
            bit_q_nxt  = bit_val;
            stop_q_nxt = stop;
            cnt_nxt    = stop ? T2 : (bit_val ? T1 : T3);
        end else begin
            case (phase)
                PH_LOW: begin
                    if (tc) begin
                        if (stop_q) begin
                            phase_nxt = PH_IDLE;
                        end else begin
                            phase_nxt = PH_HIGH;
                            cnt_nxt   = bit_q ? T3 : T1;
                        end
                    end
                end
                PH_HIGH: begin
                    if (tc) phase_nxt = PH_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/n64_ctrl_resp.sv
// n64_ctrl_resp: device-side N64 controller emulator on the single-wire bus.
// Decodes one command byte and replies with the identity word or a button snapshot.
//   clk         system clock (CLK_33)
//   reset       synchronous, active-high
//   line_in     raw bus level (asynchronous)
//   line_oe     1 = pull bus low; pad is N64_din = line_oe ? 1'b0 : 1'bz
//   buttons     button/stick word, sampled when a poll reply starts
//   cmd         last decoded command byte
//   cmd_valid   one-cycle pulse when cmd is updated
//   busy        high from stop-bit acceptance until the reply ends
//   reply_done  one-cycle pulse on the cycle the reply stop bit is released
// Build option: N64_RESP_GLITCH_FILTER_EN ignores low pulses shorter than
// CLK_PER_US/2 cycles while in IDLE or RX_WAIT.
//
// state         | meaning
// ST_IDLE       | waiting for the first falling edge of a command
// ST_RX_BIT     | counting to the mid-bit sample point
// ST_RX_WAIT    | waiting for the next bit's falling edge (with timeout)
// ST_TURNAROUND | command accepted, line-high gap before the reply
// ST_TX_BIT     | sending reply data bits
// ST_TX_STOP    | sending the reply stop bit
// ST_DISCARD    | multi-byte command: wait for a long idle-high line
module n64_ctrl_resp
    import n64_pkg::*;
#(
    parameter int          CLK_PER_US    = 33,
    parameter int          RESP_DELAY_US = 2,
    parameter int          TIMEOUT_US    = 6,
    parameter logic [23:0] ID_WORD       = 24'h050002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_in,
    output logic        line_oe,
    input  logic [31:0] buttons,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        busy,
    output logic        reply_done
);

    localparam logic [CNT_W-1:0] T_TIMEOUT = CNT_W'(TIMEOUT_US * CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] T_DELAY   = CNT_W'(RESP_DELAY_US * CLK_PER_US - 1);

    logic line_m, line_s, line_d;
    logic fall, rise, bit_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            line_m <= 1'b1;
            line_s <= 1'b1;
            line_d <= 1'b1;
        end else begin
            line_m <= line_in;
            line_s <= line_m;
            line_d <= line_s;
        end
    end

    assign fall = line_d & ~line_s;
    assign rise = ~line_d & line_s;

`ifdef N64_RESP_GLITCH_FILTER_EN
    localparam int GLITCH_MIN = CLK_PER_US / 2;
    // A bit is only recognised once the line has been low GLITCH_MIN cycles; the
    // sample-point load is shortened by the same amount so the sample still lands
    // 2 us after the real falling edge.
    localparam logic [CNT_W-1:0] T_SAMPLE = CNT_W'(2 * CLK_PER_US - GLITCH_MIN);
    logic [7:0] lo_run;

    always_ff @(posedge clk) begin
        if (reset || line_s)    lo_run <= '0;
        else if (lo_run != '1)  lo_run <= lo_run + 1'b1;
    end

    assign bit_start = ~line_s && (lo_run == 8'(GLITCH_MIN - 1));
`else
    localparam logic [CNT_W-1:0] T_SAMPLE = CNT_W'(2 * CLK_PER_US - 1);
    assign bit_start = fall;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       rx_byte, rx_byte_nxt;
    logic [30:0]      tx_sh, tx_sh_nxt;
    logic [5:0]       tx_left, tx_left_nxt;
    logic [7:0]       cmd_nxt;
    logic             cmd_valid_nxt, reply_done_nxt;
    logic             tx_start, tx_bit, tx_stop, tx_done;

    n64_bit_tx #(.CLK_PER_US(CLK_PER_US)) u_bit_tx (
        .clk     (clk),
        .reset   (reset),
        .start   (tx_start),
        .bit_val (tx_bit),
        .stop    (tx_stop),
        .line_oe (line_oe),
        .done    (tx_done)
    );

    assign busy = (state == ST_TURNAROUND) || (state == ST_TX_BIT) || (state == ST_TX_STOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            rx_byte    <= '0;
            tx_sh      <= '0;
            tx_left    <= '0;
            cmd        <= 8'h00;
            cmd_valid  <= 1'b0;
            reply_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            rx_byte    <= rx_byte_nxt;
            tx_sh      <= tx_sh_nxt;
            tx_left    <= tx_left_nxt;
            cmd        <= cmd_nxt;
            cmd_valid  <= cmd_valid_nxt;
            reply_done <= reply_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = (cnt == '0) ? cnt : cnt - 1'b1;
        bit_cnt_nxt    = bit_cnt;
        rx_byte_nxt    = rx_byte;
        tx_sh_nxt      = tx_sh;
        tx_left_nxt    = tx_left;
        cmd_nxt        = cmd;
        cmd_valid_nxt  = 1'b0;
        reply_done_nxt = 1'b0;
        tx_start       = 1'b0;
        tx_bit         = 1'b0;
        tx_stop        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bit_start) begin
                    state_nxt   = ST_RX_BIT;
                    cnt_nxt     = T_SAMPLE;
                    bit_cnt_nxt = '0;
                end
            end
            ST_RX_BIT: begin
                if (cnt == '0) begin
                    if (bit_cnt == 4'd8) begin
                        // The console stop bit is still high 1 us after its rise.
                        if (line_s) begin
                            state_nxt     = ST_TURNAROUND;
                            cnt_nxt       = T_DELAY;
                            cmd_nxt       = rx_byte;
                            cmd_valid_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        rx_byte_nxt = {rx_byte[6:0], line_s};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        state_nxt   = ST_RX_WAIT;
                        cnt_nxt     = T_TIMEOUT;
                    end
                end
            end
            ST_RX_WAIT: begin
                if (bit_start) begin
                    state_nxt = ST_RX_BIT;
                    cnt_nxt   = T_SAMPLE;
                end else if (rise) begin
                    cnt_nxt = T_TIMEOUT;
                end else if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TURNAROUND: begin
                if (fall) begin
                    state_nxt = ST_DISCARD;
                    cnt_nxt   = T_TIMEOUT;
                end else if (cnt == '0) begin
                    case (cmd)
                        CMD_POLL: begin
                            state_nxt   = ST_TX_BIT;
                            tx_start    = 1'b1;
                            tx_bit      = buttons[31];
                            tx_sh_nxt   = buttons[30:0];
                            tx_left_nxt = REPLY_LEN_POLL;
                        end
                        CMD_INFO, CMD_RESET: begin
                            state_nxt   = ST_TX_BIT;
                            tx_start    = 1'b1;
                            tx_bit      = ID_WORD[23];
                            tx_sh_nxt   = {ID_WORD[22:0], 8'h00};
                            tx_left_nxt = REPLY_LEN_ID;
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_TX_BIT: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (tx_left == 6'd1) begin
                        tx_stop   = 1'b1;
                        state_nxt = ST_TX_STOP;
                    end else begin
                        tx_bit      = tx_sh[30];
                        tx_sh_nxt   = {tx_sh[29:0], 1'b0};
                        tx_left_nxt = tx_left - 6'd1;
                    end
                end
            end
            ST_TX_STOP: begin
                if (tx_done) begin
                    state_nxt      = ST_IDLE;
                    reply_done_nxt = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (!line_s)          cnt_nxt   = T_TIMEOUT;
                else if (cnt == '0)   state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/n64_ctrl_resp.md
Name: n64_ctrl_resp

Overview:
- Device-side N64 controller emulator on the single-wire open-drain bus; responder counterpart of the console-side poller (`N64_recv`).
- Decodes one command byte from the console and replies with a 24-bit identity or a 32-bit button snapshot.
- Top level drives the pad: `N64_din = line_oe ? 1'b0 : 1'bz`; `line_in` is the raw pad value.

Parameters:
- CLK_PER_US, 33, clock cycles per microsecond (CLK_33 domain).
- RESP_DELAY_US, 2, line-high gap between console stop bit and first reply bit.
- TIMEOUT_US, 6, maximum low or high time inside a command before aborting.
- ID_WORD, 24'h050002, identity returned for commands 0x00 and 0xFF.

Ports:
- clk, input, 1, system clock (CLK_33).
- reset, input, 1, synchronous, active-high.
- line_in, input, 1, raw bus level; asynchronous.
- line_oe, output, 1, 1 = pull bus low.
- buttons, input, 32, button/stick word; sampled when a poll reply starts.
- cmd, output, 8, last decoded command byte.
- cmd_valid, output, 1, one-cycle pulse when `cmd` is updated.
- busy, output, 1, high from the stop bit being accepted until the reply ends.
- reply_done, output, 1, one-cycle pulse after the reply stop bit is released.

Behaviour:
- Reset values: `line_oe` 0, `cmd` 8'h00, `cmd_valid` 0, `busy` 0, `reply_done` 0, FSM in IDLE.
- Reset asserted mid-reply releases `line_oe` on the next clock edge.
- Input path: 2-FF synchronizer on `line_in`; a falling edge is detected on the synchronized value. All timing below is relative to that edge.
- Bit encoding, 4 us per bit:
  - '0' = 3 us low, 1 us high.
  - '1' = 1 us low, 3 us high.
  - MSB first.
- FSM states:
  - IDLE: wait for a falling edge, then go to RX_BIT.
  - RX_BIT: at 2*CLK_PER_US cycles after the fall, sample the line; high = 1, low = 0.
    - Bits 0-7 shift into the byte.
    - The 9th bit must sample high; that is the console stop bit. If it samples low, abort.
    - After sampling, go to RX_WAIT.
  - RX_WAIT: wait for the next fall, then return to RX_BIT.
    - Line low longer than TIMEOUT_US, or high longer than TIMEOUT_US, aborts to IDLE with no pulse.
  - TURNAROUND: entered on the stop bit once the line returns high.
    - Entry: `cmd` updated, `cmd_valid` pulses, `busy` set.
    - Wait RESP_DELAY_US with the line high.
    - A falling edge during the wait means a multi-byte command: drop it, clear `busy`, go to DISCARD.
    - When the delay ends, select the reply:
      - 0x01: reply length 32, data = `buttons`, latched on this cycle.
      - 0x00 or 0xFF: reply length 24, data = ID_WORD.
      - Any other command: clear `busy`, go to IDLE.
  - TX_BIT: drive low 1 or 3 us per the bit value, then release for 3 or 1 us. Repeat for the reply length.
  - TX_STOP: drive low 2 us, then release.
    - `busy` clears and `reply_done` pulses on the release cycle.
    - Then go to IDLE; the receiver is ignored throughout TX.
  - DISCARD: wait until the line has been high continuously for TIMEOUT_US, then go to IDLE.
- Timing counter: one cycle counter, 16 bits, reloaded at each phase. Phase durations are exact multiples of CLK_PER_US cycles (±0 cycles).
- A `buttons` change during TX has no effect on the reply in progress.

Optional Feature:
- Macro: N64_RESP_GLITCH_FILTER_EN.
- Defined: a low pulse shorter than CLK_PER_US/2 cycles in IDLE or RX_WAIT is ignored. The FSM stays in its state and timers continue.
- Undefined: any synchronized falling edge starts a bit.

Decomposition:
- Package `n64_pkg`:
  - command constants: CMD_INFO 8'h00, CMD_POLL 8'h01, CMD_RESET 8'hFF;
  - state enum;
  - reply length constants: 24, 32.
- One sub-module, `n64_bit_tx`: takes bit value and start, drives `line_oe` with the low/high timing, returns done.
  - Reused for the stop bit via a stop flag.
  - Shares CLK_PER_US.

Test Plan:
- Console BFM sends 0x01 with stop bit, `buttons` = 32'h8000_1234 → `cmd_valid` with `cmd` = 0x01. The line stays high 66 cycles after the stop-bit rise. The BFM then decodes 32'h8000_1234 followed by a 66-cycle stop low, and `reply_done` pulses.
- Send 0x00 → 24-bit reply decoded as 24'h050002. Repeat with 0xFF → same reply.
- Send 0x42 → `cmd_valid` with `cmd` = 0x42, `line_oe` never asserted, `busy` drops before 67 cycles.
- Send 4 bits, then hold the line high 300 cycles → no `cmd_valid`, FSM back in IDLE. A following 0x01 is answered normally.
- Assert `reset` during reply bit 10 → `line_oe` = 0 on the next cycle, all outputs at reset values. A following poll is answered normally.
- With N64_RESP_GLITCH_FILTER_EN defined, inject a 10-cycle low pulse between bits of 0x01 → command still decoded as 0x01. Without the macro, the same stimulus yields no valid poll reply.
